watch_set_ctrl: RTL and testbench

WATCH_SET_CTRL -- requirements
Module: watch_set_ctrl

---
 rtl/watch_set_ctrl_if.sv | 22 ++
 rtl/watch_set_ctrl.sv | 179 +++++++++++++++++
 tb/tb_watch_set_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/watch_set_ctrl_if.sv
// Button/time bus between the watch front panel and the set controller.
interface watch_set_ctrl_if;
    logic        btn_mode;
    logic        btn_up;
    logic        btn_down;
    logic        btn_cancel;
    logic [37:0] cur_time;
    logic        en_1hz;
    logic        set_time;
    logic [37:0] bin_time;
    logic [2:0]  edit_field;

    modport master (
        output btn_mode, btn_up, btn_down, btn_cancel, cur_time,
        input  en_1hz, set_time, bin_time, edit_field
    );

    modport slave (
        input  btn_mode, btn_up, btn_down, btn_cancel, cur_time,
        output en_1hz, set_time, bin_time, edit_field
    );
endinterface

// File: rtl/watch_set_ctrl.sv
// Watch time-set controller: field-by-field edit FSM, commit strobe and 1 Hz prescaler.
// Optional macro WATCH_SET_LEAP_EN enables Gregorian leap-year February (29 days).
module watch_set_ctrl #(
    parameter int unsigned CLK_DIV = 50000000
) (
    input  logic            clk,
    input  logic            rst,
    watch_set_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        E_YEAR = 3'd1,
        E_MONTH = 3'd2,
        E_DAY  = 3'd3,
        E_HOUR = 3'd4,
        E_MIN  = 3'd5,
        E_SEC  = 3'd6,
        COMMIT = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [11:0]      year_q, year_d;
    logic [3:0]       month_q, month_d;
    logic [4:0]       day_q, day_d;
    logic [4:0]       hour_q, hour_d;
    logic [5:0]       min_q, min_d;
    logic [5:0]       sec_q, sec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_1hz_q, en_1hz_d;
    logic             set_time_q, set_time_d;

    logic       adj_c;
    logic [4:0] md_c;
    logic [3:0] cap_month_c;
    logic [4:0] cap_hour_c;
    logic [5:0] cap_min_c;
    logic [5:0] cap_sec_c;

`ifdef WATCH_SET_LEAP_EN
    function automatic logic [4:0] max_day(input logic [11:0] y, input logic [3:0] m);
        logic [4:0] r;
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: r = 5'd30;
            4'd2: begin
                if ((y[1:0] == 2'b00) &&
                    (((y % 12'd100) != 12'd0) || ((y % 12'd400) == 12'd0)))
                    r = 5'd29;
                else
                    r = 5'd28;
            end
            default: r = 5'd31;
        endcase
        return r;
    endfunction
`else
    function automatic logic [4:0] max_day(input logic [3:0] m);
        logic [4:0] r;
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: r = 5'd30;
            4'd2:                    r = 5'd28;
            default:                 r = 5'd31;
        endcase
        return r;
    endfunction
`endif

    // One step up or down inside [lo, hi], wrapping at either end.
    function automatic logic [11:0] step(input logic [11:0] v, input logic [11:0] lo,
                                         input logic [11:0] hi, input logic up);
        if (up)
            return (v >= hi) ? lo : v + 12'd1;
        else
            return (v <= lo) ? hi : v - 12'd1;
    endfunction

    // Next-state, edit-register, prescaler and strobe logic.
    always_comb begin
        state_d    = state_q;
        year_d     = year_q;
        month_d    = month_q;
        day_d      = day_q;
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        cnt_d      = '0;
        en_1hz_d   = 1'b0;
        set_time_d = 1'b0;

        adj_c = bus.btn_up ^ bus.btn_down;
`ifdef WATCH_SET_LEAP_EN
        md_c = max_day(year_q, month_q);
`else
        md_c = max_day(month_q);
`endif
        cap_month_c = bus.cur_time[25:22];
        cap_hour_c  = bus.cur_time[16:12];
        cap_min_c   = bus.cur_time[11:6];
        cap_sec_c   = bus.cur_time[5:0];

        case (state_q)
            RUN: begin
                if (!bus.btn_cancel && bus.btn_mode) begin
                    year_d  = bus.cur_time[37:26];
                    month_d = (cap_month_c == 4'd0 || cap_month_c > 4'd12) ? 4'd1 : cap_month_c;
                    day_d   = bus.cur_time[21:17];
                    hour_d  = (cap_hour_c > 5'd23) ? 5'd0 : cap_hour_c;
                    min_d   = (cap_min_c > 6'd59) ? 6'd0 : cap_min_c;
                    sec_d   = (cap_sec_c > 6'd59) ? 6'd0 : cap_sec_c;
                    state_d = E_YEAR;
                end
            end
            COMMIT: state_d = RUN;
            default: begin
                if (bus.btn_cancel) begin
                    state_d = RUN;
                end else if (bus.btn_mode) begin
                    state_d = state_t'(3'(state_q + 3'd1));
                    if (state_q == E_MONTH) begin
                        if (day_q == 5'd0)
                            day_d = 5'd1;
                        else if (day_q > md_c)
                            day_d = md_c;
                    end
                end else if (adj_c) begin
                    case (state_q)
                        E_YEAR:  year_d  = step(year_q, 12'd0, 12'd4095, bus.btn_up);
                        E_MONTH: month_d = 4'(step(12'(month_q), 12'd1, 12'd12, bus.btn_up));
                        E_DAY:   day_d   = 5'(step(12'(day_q), 12'd1, 12'(md_c), bus.btn_up));
                        E_HOUR:  hour_d  = 5'(step(12'(hour_q), 12'd0, 12'd23, bus.btn_up));
                        E_MIN:   min_d   = 6'(step(12'(min_q), 12'd0, 12'd59, bus.btn_up));
                        E_SEC:   sec_d   = 6'(step(12'(sec_q), 12'd0, 12'd59, bus.btn_up));
                        default: ;
                    endcase
                end
            end
        endcase

        // Prescaler only runs while staying in RUN; restarts from 0 on every entry.
        if (state_q == RUN && state_d == RUN)
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        en_1hz_d   = (state_d == RUN) && (cnt_d == CNT_LAST);
        set_time_d = (state_d == COMMIT);
    end

    // State, edit registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            year_q     <= '0;
            month_q    <= '0;
            day_q      <= '0;
            hour_q     <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            cnt_q      <= '0;
            en_1hz_q   <= 1'b0;
            set_time_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            year_q     <= year_d;
            month_q    <= month_d;
            day_q      <= day_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            cnt_q      <= cnt_d;
            en_1hz_q   <= en_1hz_d;
            set_time_q <= set_time_d;
        end
    end

    assign bus.en_1hz     = en_1hz_q;
    assign bus.set_time   = set_time_q;
    assign bus.bin_time   = {year_q, month_q, day_q, hour_q, min_q, sec_q};
    assign bus.edit_field = state_q;
endmodule

// File: tb/tb_watch_set_ctrl.sv
// Directed, table-driven bench for watch_set_ctrl (CLK_DIV = 4).
module tb_watch_set_ctrl;
    localparam int unsigned CLK_DIV = 4;
`ifdef WATCH_SET_LEAP_EN
    localparam int FEB_LEAP = 29;
`else
    localparam int FEB_LEAP = 28;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    watch_set_ctrl_if bus ();
    watch_set_ctrl #(.CLK_DIV(CLK_DIV)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        mode;
        logic        up;
        logic        down;
        logic        cancel;
        logic [37:0] cur;
        logic [2:0]  exp_field;
        logic        exp_set;
        logic [37:0] exp_bin;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [37:0] tm(input int y, input int m, input int d,
                                       input int h, input int mi, input int s);
        return {12'(y), 4'(m), 5'(d), 5'(h), 6'(mi), 6'(s)};
    endfunction

    task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic m, input logic u, input logic d, input logic c,
                       input logic [37:0] cur, input int f, input logic s, input logic [37:0] b);
        vec_t v;
        v.mode = m; v.up = u; v.down = d; v.cancel = c; v.cur = cur;
        v.exp_field = 3'(f); v.exp_set = s; v.exp_bin = b;
        vecs.push_back(v);
    endtask

    // Drive one single-cycle button pattern, then sample just after the edge.
    task automatic press(input logic m, input logic u, input logic d, input logic c,
                         input logic [37:0] cur);
        @(negedge clk);
        bus.btn_mode = m; bus.btn_up = u; bus.btn_down = d; bus.btn_cancel = c;
        bus.cur_time = cur;
        @(posedge clk);
        #1;
        bus.btn_mode = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_cancel = 1'b0;
    endtask

    initial begin
        logic [37:0] t0, t1, t2, t3, t4, t5;
        t0 = tm(2023, 12, 31, 23, 59, 59);
        t1 = tm(2023, 6, 15, 10, 59, 30);
        t2 = tm(100, 13, 0, 25, 60, 63);
        t3 = tm(2024, 1, 31, 12, 0, 0);
        t4 = tm(2100, 1, 31, 12, 0, 0);
        t5 = tm(0, 2, 29, 0, 0, 0);

        // Full pass with no edits: one commit, bin equals cur_time.
        for (int i = 1; i <= 6; i++) add(1, 0, 0, 0, t0, i, 0, t0);
        add(1, 0, 0, 0, t0, 7, 1, t0);
        add(0, 0, 0, 0, t0, 0, 0, t0);
        // Minute wrap and simultaneous up/down, then cancel keeps edits.
        for (int i = 1; i <= 5; i++) add(1, 0, 0, 0, t1, i, 0, t1);
        add(0, 1, 0, 0, t1, 5, 0, tm(2023, 6, 15, 10, 0, 30));
        add(0, 0, 1, 0, t1, 5, 0, tm(2023, 6, 15, 10, 59, 30));
        add(0, 1, 1, 0, t1, 5, 0, tm(2023, 6, 15, 10, 59, 30));
        add(0, 0, 1, 0, t1, 5, 0, tm(2023, 6, 15, 10, 58, 30));
        add(0, 0, 0, 1, t1, 0, 0, tm(2023, 6, 15, 10, 58, 30));
        add(0, 1, 0, 0, t1, 0, 0, tm(2023, 6, 15, 10, 58, 30));
        // Capture sanitising, month/day/hour wraps, cancel in E_HOUR.
        add(1, 0, 0, 0, t2, 1, 0, tm(100, 1, 0, 0, 0, 0));
        add(0, 0, 1, 0, t2, 1, 0, tm(99, 1, 0, 0, 0, 0));
        add(1, 0, 0, 0, t2, 2, 0, tm(99, 1, 0, 0, 0, 0));
        add(0, 0, 1, 0, t2, 2, 0, tm(99, 12, 0, 0, 0, 0));
        add(0, 1, 0, 0, t2, 2, 0, tm(99, 1, 0, 0, 0, 0));
        add(0, 0, 1, 0, t2, 2, 0, tm(99, 12, 0, 0, 0, 0));
        add(1, 0, 0, 0, t2, 3, 0, tm(99, 12, 1, 0, 0, 0));
        add(0, 0, 1, 0, t2, 3, 0, tm(99, 12, 31, 0, 0, 0));
        add(0, 1, 0, 0, t2, 3, 0, tm(99, 12, 1, 0, 0, 0));
        add(1, 0, 0, 0, t2, 4, 0, tm(99, 12, 1, 0, 0, 0));
        add(0, 0, 1, 0, t2, 4, 0, tm(99, 12, 1, 23, 0, 0));
        add(0, 1, 0, 0, t2, 4, 0, tm(99, 12, 1, 0, 0, 0));
        add(0, 0, 1, 0, t2, 4, 0, tm(99, 12, 1, 23, 0, 0));
        add(0, 0, 0, 1, t2, 0, 0, tm(99, 12, 1, 23, 0, 0));
        // Year 0 wraps and is a 400-year leap year; cancel beats mode.
        add(1, 0, 0, 0, t5, 1, 0, t5);
        add(0, 0, 1, 0, t5, 1, 0, tm(4095, 2, 29, 0, 0, 0));
        add(0, 1, 0, 0, t5, 1, 0, t5);
        add(1, 0, 0, 0, t5, 2, 0, t5);
        add(1, 0, 0, 0, t5, 3, 0, tm(0, 2, FEB_LEAP, 0, 0, 0));
        add(1, 0, 0, 1, t5, 0, 0, tm(0, 2, FEB_LEAP, 0, 0, 0));
        // February 2024 clamp.
        add(1, 0, 0, 0, t3, 1, 0, t3);
        add(1, 0, 0, 0, t3, 2, 0, t3);
        add(0, 1, 0, 0, t3, 2, 0, tm(2024, 2, 31, 12, 0, 0));
        add(1, 0, 0, 0, t3, 3, 0, tm(2024, 2, FEB_LEAP, 12, 0, 0));
        add(0, 0, 0, 1, t3, 0, 0, tm(2024, 2, FEB_LEAP, 12, 0, 0));
        // February 2100 is never leap; day wraps at 28; mode beats up.
        add(1, 0, 0, 0, t4, 1, 0, t4);
        add(1, 0, 0, 0, t4, 2, 0, t4);
        add(0, 1, 0, 0, t4, 2, 0, tm(2100, 2, 31, 12, 0, 0));
        add(1, 0, 0, 0, t4, 3, 0, tm(2100, 2, 28, 12, 0, 0));
        add(0, 1, 0, 0, t4, 3, 0, tm(2100, 2, 1, 12, 0, 0));
        add(0, 0, 1, 0, t4, 3, 0, tm(2100, 2, 28, 12, 0, 0));
        add(1, 1, 0, 0, t4, 4, 0, tm(2100, 2, 28, 12, 0, 0));
        add(0, 0, 0, 1, t4, 0, 0, tm(2100, 2, 28, 12, 0, 0));
        add(1, 0, 0, 1, t4, 0, 0, tm(2100, 2, 28, 12, 0, 0));

        rst = 1'b1;
        bus.btn_mode = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_cancel = 1'b0;
        bus.cur_time = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset edit_field", 38'(bus.edit_field), 38'd0);
        check("reset set_time", 38'(bus.set_time), 38'd0);
        check("reset en_1hz", 38'(bus.en_1hz), 38'd0);
        check("reset bin_time", bus.bin_time, 38'd0);

        // Prescaler after reset release: high after edges 3, 7, 11 (count == CLK_DIV-1).
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("en_1hz after release edge %0d", k), 38'(bus.en_1hz),
                  38'((k % 4) == 3));
        end

        foreach (vecs[i]) begin
            press(vecs[i].mode, vecs[i].up, vecs[i].down, vecs[i].cancel, vecs[i].cur);
            check($sformatf("row %0d edit_field", i), 38'(bus.edit_field), 38'(vecs[i].exp_field));
            check($sformatf("row %0d set_time", i), 38'(bus.set_time), 38'(vecs[i].exp_set));
            check($sformatf("row %0d bin_time", i), bus.bin_time, vecs[i].exp_bin);
        end

        // Commit pass, then the prescaler restarts from 0 on re-entering RUN.
        for (int i = 1; i <= 7; i++) begin
            press(1, 0, 0, 0, t1);
            check($sformatf("commit seq field %0d", i), 38'(bus.edit_field), 38'(i));
            check($sformatf("commit seq set %0d", i), 38'(bus.set_time), 38'(i == 7));
            check($sformatf("commit seq en %0d", i), 38'(bus.en_1hz), 38'd0);
        end
        check("commit bin_time", bus.bin_time, t1);
        for (int k = 0; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post-commit field %0d", k), 38'(bus.edit_field), 38'd0);
            check($sformatf("post-commit set %0d", k), 38'(bus.set_time), 38'd0);
            check($sformatf("post-commit en %0d", k), 38'(bus.en_1hz), 38'(k == 3));
        end

        // Reset in E_SEC discards the edit immediately; no commit afterwards.
        for (int i = 1; i <= 6; i++) press(1, 0, 0, 0, t0);
        check("pre-reset field", 38'(bus.edit_field), 38'd6);
        #2;
        rst = 1'b1;
        #1;
        check("async reset field", 38'(bus.edit_field), 38'd0);
        check("async reset set", 38'(bus.set_time), 38'd0);
        check("async reset en", 38'(bus.en_1hz), 38'd0);
        check("async reset bin", bus.bin_time, 38'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post-reset set %0d", k), 38'(bus.set_time), 38'd0);
            check($sformatf("post-reset field %0d", k), 38'(bus.edit_field), 38'd0);
            check($sformatf("post-reset en %0d", k), 38'(bus.en_1hz), 38'((k % 4) == 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
